moving_average_peak_detect: RTL
===============================

MOVING_AVERAGE_PEAK_DETECT -- requirements
Module: moving_average_peak_detect

Interface
REQ-001 Parameter THRESH_HI, default 32: signed 8-bit upper hysteresis threshold (arm level).
REQ-002 Parameter THRESH_LO, default 16: signed 8-bit lower hysteresis threshold (release level); THRESH_LO < THRESH_HI SHALL hold, with violation a compile-time error.
REQ-003 Parameter MIN_DWELL, default 4, range 1..255: minimum TRACK samples for a valid peak.
REQ-004 system1000  in  1  clock, all state on rising edge.
REQ-005 system1000_rst  in  1  asynchronous, active-high reset.
REQ-006 avg_i  in  8  signed moving-average sample, one new sample every clock, no valid strobe.
REQ-007 peak_o  out  8  signed value of last emitted peak.
REQ-008 peak_valid_o  out  1  one-cycle strobe, peak_o updated this cycle.
REQ-009 peak_count_o  out  16  number of emitted peaks, saturating.
REQ-010 busy_o  out  1  high while in TRACK.
REQ-011 peak_time_o  out  16  cycle timestamp of emitted peak sample; present only with PEAK_DETECT_TIMESTAMP_EN.

Function
REQ-012 All comparisons SHALL be signed 8-bit (0x80 = -128); no widening beyond 8 bits for sample or peak.
REQ-013 FSM states SHALL be IDLE and TRACK; internal registers: peak (8b signed), dwell (8b).
REQ-014 IDLE, avg_i > THRESH_HI: next TRACK, peak <= avg_i, dwell <= 1; otherwise stay IDLE.
REQ-015 TRACK, avg_i >= THRESH_LO: stay TRACK, peak <= max(peak, avg_i), dwell <= dwell+1 saturating at MIN_DWELL.
REQ-016 TRACK, avg_i < THRESH_LO and dwell >= MIN_DWELL: next IDLE; at same edge peak_o <= peak, peak_valid_o <= 1, peak_count_o increments.
REQ-017 TRACK, avg_i < THRESH_LO and dwell < MIN_DWELL: next IDLE, pulse discarded, outputs unchanged.
REQ-018 Releasing sample SHALL NOT enter the max; equal-to-peak samples SHALL leave peak unchanged.
REQ-019 Latency: peak_valid_o registered, high exactly one cycle immediately following the edge that samples the releasing value.
REQ-020 peak_valid_o SHALL be low in every other cycle; two strobes SHALL be separated by at least MIN_DWELL+1 cycles.
REQ-021 peak_o SHALL hold its value between strobes.
REQ-022 peak_count_o SHALL saturate at 16'hFFFF; further peaks still strobe peak_valid_o and update peak_o.
REQ-023 busy_o SHALL be a registered decode of state == TRACK.

Reset
REQ-024 system1000_rst high SHALL immediately force state IDLE, peak, dwell, peak_o, peak_valid_o, peak_count_o, busy_o (and peak_time_o, timestamp counter) to 0, regardless of clock.
REQ-025 Reset asserted mid-TRACK SHALL discard the in-progress pulse with no strobe; first sample evaluated is at first rising edge after deassertion.

Configuration
REQ-026 Macro PEAK_DETECT_TIMESTAMP_EN defined: 16-bit free-running cycle counter (wrap 0xFFFF->0) and peak_time_o present; peak_time_o <= counter value at the edge where the current peak was captured, updated with peak_o.
REQ-027 Macro undefined: no counter, no peak_time_o port; all other behaviour identical.

Verification (defaults HI=32, LO=16, DWELL=4)
REQ-028 avg_i 0,40,50,70,60,10 -> one strobe in cycle after sample 10, peak_o=70, peak_count_o=1, busy_o low after strobe.
REQ-029 avg_i 0,40,50,20,10 (3 TRACK samples) -> no strobe, peak_count_o=0, peak_o=0.
REQ-030 avg_i 40,45,20,30,50,17,5 -> single strobe, peak_o=50 (hysteresis holds TRACK between 16 and 32).
REQ-031 avg_i 0x80 (-128) and 0x21 (33) sequences -> -128 never arms; 33 arms, busy_o=1 next cycle.
REQ-032 Reset pulsed during TRACK of avg 40,60,70 -> all outputs 0 asynchronously, no strobe; 65536 valid peaks -> peak_count_o=65535.
REQ-033 With PEAK_DETECT_TIMESTAMP_EN, reset release, sample 70 captured at counter value 5 -> strobe with peak_time_o=5.

Source files
------------

// File: rtl/moving_average_peak_detect.sv
// moving_average_peak_detect: hysteresis peak detector on a signed 8-bit moving-average stream.
//   system1000      clock, all state on rising edge
//   system1000_rst  asynchronous active-high reset
//   avg_i           signed sample, one per clock
//   peak_o          signed value of the last emitted peak
//   peak_valid_o    one-cycle strobe when peak_o updates
//   peak_count_o    saturating count of emitted peaks
//   busy_o          high while tracking a pulse
//   peak_time_o     cycle stamp of the emitted peak sample (only with PEAK_DETECT_TIMESTAMP_EN)
module moving_average_peak_detect #(
  parameter logic signed [7:0] THRESH_HI = 8'sd32,
  parameter logic signed [7:0] THRESH_LO = 8'sd16,
  parameter int unsigned       MIN_DWELL = 4
)(
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic signed [7:0] avg_i,
  output logic signed [7:0] peak_o,
  output logic              peak_valid_o,
  output logic [15:0]       peak_count_o,
  output logic              busy_o
`ifdef PEAK_DETECT_TIMESTAMP_EN
  ,output logic [15:0]      peak_time_o
`endif
);
  localparam logic [7:0] DWELL_MAX = 8'(MIN_DWELL);
  if (THRESH_LO >= THRESH_HI) begin : g_bad_thresh
    $error("THRESH_LO must be below THRESH_HI");
  end
  if (MIN_DWELL < 1 || MIN_DWELL > 255) begin : g_bad_dwell
    $error("MIN_DWELL must be in 1..255");
  end
  typedef enum logic {IDLE, TRACK} state_t;
  state_t            state, state_n;
  logic signed [7:0] peak, peak_n;
  logic [7:0]        dwell, dwell_n;
  logic [15:0]       peak_cnt;
  logic              arm, below, take, emit;
  assign peak_count_o = peak_cnt;
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    arm     = avg_i > THRESH_HI;
    below   = avg_i < THRESH_LO;
    state_n = state == IDLE ? (arm ? TRACK : IDLE) : (below ? IDLE : TRACK);
  end
  // The releasing sample never enters the max; ties keep the earlier peak.
  always_comb begin
    take    = state == IDLE ? arm : (!below && avg_i > peak);
    emit    = state == TRACK && below && dwell >= DWELL_MAX;
    peak_n  = take ? avg_i : peak;
    dwell_n = state == IDLE ? (arm ? 8'd1 : dwell) : (dwell >= DWELL_MAX ? dwell : dwell + 8'd1);
  end
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      peak         <= '0;
      dwell        <= '0;
      peak_o       <= '0;
      peak_valid_o <= 1'b0;
      peak_cnt     <= '0;
      busy_o       <= 1'b0;
    end else begin
      peak         <= peak_n;
      dwell        <= dwell_n;
      peak_valid_o <= emit;
      busy_o       <= state_n == TRACK;
      if (emit) peak_o <= peak;
      if (emit && peak_cnt != 16'hFFFF) peak_cnt <= peak_cnt + 16'd1;
    end
`ifdef PEAK_DETECT_TIMESTAMP_EN
  logic [15:0] ts_cnt, peak_t;
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      ts_cnt      <= '0;
      peak_t      <= '0;
      peak_time_o <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (take) peak_t <= ts_cnt;
      if (emit) peak_time_o <= peak_t;
    end
`endif
endmodule
